// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer: bit/slot position counters for a serial audio frame.
// Advances one position per BitTick. In master mode it free-runs; in slave mode it
// follows LRCLKIn edges. It issues the word-load (Ld), per-slot capture (En) and
// frame (NewFrame) strobes. Slave-mode misalignment raises a sticky SyncErr flag.
module audio_frame_sequencer #(
    parameter int WORD_BITS    = 32,
    parameter int SLOTS        = 2,
    parameter int CAPTURE_BIT  = 25,
    parameter int NEWFRAME_BIT = 26,
    parameter int DELAY        = 1,
    localparam int BW = $clog2(WORD_BITS),
    localparam int SW = (SLOTS > 2) ? $clog2(SLOTS) : 1
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             BitTick,
    input  logic             Enable,
    input  logic             Mode,
    input  logic             LRCLKIn,
    output logic             LRCLK,
    output logic [BW-1:0]    BitCount,
    output logic [SW-1:0]    Slot,
    output logic             Ld,
    output logic [SLOTS-1:0] En,
    output logic             NewFrame,
    output logic             SyncErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_BITS - 1);
    localparam logic [BW-1:0] CAP_BIT   = BW'(CAPTURE_BIT);
    localparam logic [BW-1:0] NF_BIT    = BW'(NEWFRAME_BIT);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [SW-1:0] HALF_SLOT = SW'(SLOTS / 2);

    state_t           state_r;
    logic             mode_r;      // Mode latched when leaving IDLE
    logic             first_r;     // master: next tick loads (0,0)
    logic [DELAY:0]   line_r;      // tick-sampled LRCLKIn, [0] newest

    logic [DELAY+1:0] chain_s;
    logic             fall_s;
    logic             rise_s;
    logic             update_s;
    logic             mis_s;
    logic [BW-1:0]    nat_bc_s;
    logic [SW-1:0]    nat_slot_s;
    logic [BW-1:0]    new_bc_s;
    logic [SW-1:0]    new_slot_s;

    // One-hot capture strobe for the slot being entered
    function automatic logic [SLOTS-1:0] capture_strobe(input logic [BW-1:0] bc,
                                                        input logic [SW-1:0] slot);
        logic [SLOTS-1:0] v;
        if (bc == CAP_BIT) begin
            v = SLOTS'(1'b1) << slot;
        end else begin
            v = {SLOTS{1'b0}};
        end
        return v;
    endfunction

    // Edge recognition on the sample line plus natural/forced next position
    always_comb begin
        chain_s = {line_r, LRCLKIn};
        // edge between the two oldest stages once the current sample is shifted in
        fall_s  = mode_r & chain_s[DELAY+1] & ~chain_s[DELAY];
        rise_s  = mode_r & ~chain_s[DELAY+1] & chain_s[DELAY];

        if (BitCount == LAST_BIT) begin
            nat_bc_s   = {BW{1'b0}};
            nat_slot_s = Slot + SW'(1'b1);
        end else begin
            nat_bc_s   = BitCount + BW'(1'b1);
            nat_slot_s = Slot;
        end

        mis_s = 1'b0;
        if ((state_r != RUN) || first_r) begin
            new_bc_s   = {BW{1'b0}};
            new_slot_s = {SW{1'b0}};
        end else if (fall_s) begin
            new_bc_s   = {BW{1'b0}};
            new_slot_s = {SW{1'b0}};
            mis_s      = (nat_bc_s != {BW{1'b0}}) || (nat_slot_s != {SW{1'b0}});
        end else if (rise_s) begin
            new_bc_s   = {BW{1'b0}};
            new_slot_s = HALF_SLOT;
            mis_s      = (nat_bc_s != {BW{1'b0}}) || (nat_slot_s != HALF_SLOT);
        end else begin
            new_bc_s   = nat_bc_s;
            new_slot_s = nat_slot_s;
        end

        if (state_r == RUN) begin
            update_s = BitTick;
        end else if (state_r == HUNT) begin
            update_s = BitTick & fall_s;
        end else begin
            update_s = 1'b0;
        end
    end

    // Sequencer FSM with registered position, LRCLK, strobes and error flag
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r  <= IDLE;
            mode_r   <= 1'b0;
            first_r  <= 1'b0;
            line_r   <= {(DELAY+1){1'b0}};
            LRCLK    <= 1'b0;
            BitCount <= {BW{1'b0}};
            Slot     <= {SW{1'b0}};
            Ld       <= 1'b0;
            En       <= {SLOTS{1'b0}};
            NewFrame <= 1'b0;
            SyncErr  <= 1'b0;
        end else if (!Enable) begin
            state_r  <= IDLE;
            mode_r   <= 1'b0;
            first_r  <= 1'b0;
            line_r   <= {(DELAY+1){1'b0}};
            LRCLK    <= 1'b0;
            BitCount <= {BW{1'b0}};
            Slot     <= {SW{1'b0}};
            Ld       <= 1'b0;
            En       <= {SLOTS{1'b0}};
            NewFrame <= 1'b0;
            SyncErr  <= 1'b0;
        end else begin
            Ld       <= 1'b0;
            En       <= {SLOTS{1'b0}};
            NewFrame <= 1'b0;
            case (state_r)
                IDLE: begin
                    mode_r  <= Mode;
                    first_r <= ~Mode;
                    state_r <= Mode ? HUNT : RUN;
                end
                HUNT: begin
                    if (BitTick && fall_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (BitTick) begin
                        first_r <= 1'b0;
                        if (mis_s) begin
                            SyncErr <= 1'b1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase

            if (BitTick && mode_r && (state_r != IDLE)) begin
                line_r <= chain_s[DELAY:0];
            end

            if (update_s) begin
                BitCount <= new_bc_s;
                Slot     <= new_slot_s;
                LRCLK    <= (new_slot_s >= HALF_SLOT);
                Ld       <= (new_bc_s == {BW{1'b0}});
                En       <= capture_strobe(new_bc_s, new_slot_s);
                NewFrame <= (new_slot_s == LAST_SLOT) && (new_bc_s == NF_BIT);
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Testbench for audio_frame_sequencer: two instances (stereo defaults and a
// 16-bit 4-slot TDM variant) share stimulus; a position-in-frame reference model
// predicts every output each cycle, plus a directed vector table and corner sequences.
module tb_audio_frame_sequencer;

    logic clk;
    logic nReset;
    logic BitTick;
    logic Enable;
    logic Mode;
    logic LRCLKIn;

    logic       lr0, ld0, nf0, err0;
    logic [4:0] bc0;
    logic [0:0] sl0;
    logic [1:0] en0;
    logic       lr1, ld1, nf1, err1;
    logic [3:0] bc1;
    logic [1:0] sl1;
    logic [3:0] en1;

    audio_frame_sequencer dut0 (
        .Clk(clk), .nReset(nReset), .BitTick(BitTick), .Enable(Enable), .Mode(Mode),
        .LRCLKIn(LRCLKIn), .LRCLK(lr0), .BitCount(bc0), .Slot(sl0), .Ld(ld0), .En(en0),
        .NewFrame(nf0), .SyncErr(err0)
    );

    audio_frame_sequencer #(
        .WORD_BITS(16), .SLOTS(4), .CAPTURE_BIT(3), .NEWFRAME_BIT(10), .DELAY(1)
    ) dut1 (
        .Clk(clk), .nReset(nReset), .BitTick(BitTick), .Enable(Enable), .Mode(Mode),
        .LRCLKIn(LRCLKIn), .LRCLK(lr1), .BitCount(bc1), .Slot(sl1), .Ld(ld1), .En(en1),
        .NewFrame(nf1), .SyncErr(err1)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position expressed as an index within the frame
    localparam int DLY = 1;
    int  W   [2] = '{32, 16};
    int  S   [2] = '{2, 4};
    int  CAP [2] = '{25, 3};
    int  NF  [2] = '{26, 10};
    int  st;          // 0 idle, 1 hunt, 2 run
    bit  first_m;
    bit  mode_m;
    int  p   [2];
    bit  err [2];
    bit  eld [2];
    int  een [2];
    bit  enf [2];
    bit  smp [$];     // every LRCLKIn value sampled on a slave tick
    int  lr_c;

    typedef struct {
        int tick; int dut; int bc; int slot; int ld; int en; int nf; int lr;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_strobes(input int k);
        int bc, sl;
        bc = p[k] % W[k];
        sl = p[k] / W[k];
        eld[k] = (bc == 0);
        een[k] = (bc == CAP[k]) ? (1 << sl) : 0;
        enf[k] = (sl == S[k] - 1) && (bc == NF[k]);
    endtask

    task automatic model_reset();
        st = 0; first_m = 1'b0; mode_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p[k] = 0; err[k] = 1'b0; eld[k] = 1'b0; een[k] = 0; enf[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        bit fall, rise;
        int n, nat, f;
        fall = 1'b0; rise = 1'b0;
        for (int k = 0; k < 2; k++) begin
            eld[k] = 1'b0; een[k] = 0; enf[k] = 1'b0;
        end
        if (!Enable) begin
            model_reset();
        end else if (st == 0) begin
            mode_m = Mode; first_m = !Mode; st = Mode ? 1 : 2;
            smp.delete();
            for (int i = 0; i <= DLY; i++) smp.push_back(1'b0);
        end else if (BitTick) begin
            if (mode_m) begin
                smp.push_back(LRCLKIn);
                n = smp.size();
                fall = smp[n-2-DLY] && !smp[n-1-DLY];
                rise = !smp[n-2-DLY] && smp[n-1-DLY];
            end
            if (st == 1) begin
                if (fall) begin
                    st = 2;
                    for (int k = 0; k < 2; k++) begin p[k] = 0; set_strobes(k); end
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    nat = (p[k] + 1) % (W[k] * S[k]);
                    f = rise ? (S[k] / 2) * W[k] : 0;
                    if (first_m) p[k] = 0;
                    else if (fall || rise) begin
                        if (nat != f) err[k] = 1'b1;
                        p[k] = f;
                    end else p[k] = nat;
                    set_strobes(k);
                end
                first_m = 1'b0;
            end
        end
    endtask

    task automatic compare_one(input int k, input int lr, input int bc, input int sl,
                               input int ld, input int en, input int nf, input int er);
        check($sformatf("d%0d_bc", k), bc, p[k] % W[k]);
        check($sformatf("d%0d_slot", k), sl, p[k] / W[k]);
        check($sformatf("d%0d_lrclk", k), lr, ((p[k] / W[k]) >= S[k] / 2) ? 1 : 0);
        check($sformatf("d%0d_ld", k), ld, int'(eld[k]));
        check($sformatf("d%0d_en", k), en, een[k]);
        check($sformatf("d%0d_nf", k), nf, int'(enf[k]));
        check($sformatf("d%0d_syncerr", k), er, int'(err[k]));
    endtask

    task automatic compare_all();
        compare_one(0, int'(lr0), int'(bc0), int'(sl0), int'(ld0), int'(en0), int'(nf0), int'(err0));
        compare_one(1, int'(lr1), int'(bc1), int'(sl1), int'(ld1), int'(en1), int'(nf1), int'(err1));
    endtask

    // One clock: inputs applied after the falling edge, outputs checked 1 ns after the rising edge
    task automatic step(input bit t);
        BitTick = t;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic slave_tick();
        LRCLKIn = ((lr_c / 32) % 2 == 0);
        step(1'b1);
        lr_c++;
    endtask

    task automatic check_vec(input int i);
        int a_bc, a_sl, a_ld, a_en, a_nf, a_lr;
        if (vecs[i].dut == 0) begin
            a_bc = int'(bc0); a_sl = int'(sl0); a_ld = int'(ld0);
            a_en = int'(en0); a_nf = int'(nf0); a_lr = int'(lr0);
        end else begin
            a_bc = int'(bc1); a_sl = int'(sl1); a_ld = int'(ld1);
            a_en = int'(en1); a_nf = int'(nf1); a_lr = int'(lr1);
        end
        check($sformatf("vec%0d_bc", i), a_bc, vecs[i].bc);
        check($sformatf("vec%0d_slot", i), a_sl, vecs[i].slot);
        check($sformatf("vec%0d_ld", i), a_ld, vecs[i].ld);
        check($sformatf("vec%0d_en", i), a_en, vecs[i].en);
        check($sformatf("vec%0d_nf", i), a_nf, vecs[i].nf);
        check($sformatf("vec%0d_lrclk", i), a_lr, vecs[i].lr);
    endtask

    initial begin
        int n;
        bit t;
        // tick, dut, bc, slot, ld, en, nf, lrclk  (master, one tick per 4 clocks)
        vecs[0]  = '{1,  0, 0,  0, 1, 0, 0, 0};
        vecs[1]  = '{1,  1, 0,  0, 1, 0, 0, 0};
        vecs[2]  = '{2,  0, 1,  0, 0, 0, 0, 0};
        vecs[3]  = '{4,  1, 3,  0, 0, 1, 0, 0};
        vecs[4]  = '{20, 1, 3,  1, 0, 2, 0, 0};
        vecs[5]  = '{26, 0, 25, 0, 0, 1, 0, 0};
        vecs[6]  = '{27, 0, 26, 0, 0, 0, 0, 0};
        vecs[7]  = '{33, 0, 0,  1, 1, 0, 0, 1};
        vecs[8]  = '{36, 1, 3,  2, 0, 4, 0, 1};
        vecs[9]  = '{52, 1, 3,  3, 0, 8, 0, 1};
        vecs[10] = '{58, 0, 25, 1, 0, 2, 0, 1};
        vecs[11] = '{59, 0, 26, 1, 0, 0, 1, 1};
        vecs[12] = '{59, 1, 10, 3, 0, 0, 1, 1};
        vecs[13] = '{64, 0, 31, 1, 0, 0, 0, 1};
        vecs[14] = '{65, 0, 0,  0, 1, 0, 0, 0};
        vecs[15] = '{65, 1, 0,  0, 1, 0, 0, 0};

        nReset = 1'b0; Enable = 1'b0; Mode = 1'b0; BitTick = 1'b0; LRCLKIn = 1'b0;
        lr_c = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        nReset = 1'b1;
        step(1'b1);

        // Master, directed table
        Enable = 1'b1; Mode = 1'b0;
        step(1'b0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            while (n < vecs[i].tick) begin
                if (n > 0) repeat (3) step(1'b0);
                step(1'b1);
                n++;
            end
            check_vec(i);
        end

        // Enable dropped together with a tick at (Slot 1, BitCount 10)
        Enable = 1'b0; step(1'b0);
        Enable = 1'b1; step(1'b0);
        repeat (43) step(1'b1);
        check("drop_pre_bc", int'(bc0), 10);
        Enable = 1'b0; step(1'b1);
        check("drop_ld", int'(ld0), 0);
        check("drop_bc", int'(bc0), 0);
        Enable = 1'b1; step(1'b0);
        step(1'b1);
        check("reen_ld", int'(ld0), 1);
        check("reen_bc", int'(bc0), 0);

        // Asynchronous reset mid-frame
        repeat (39) step(1'b1);
        #2 nReset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        nReset = 1'b1;
        step(1'b0);
        repeat (70) step(1'b1);

        // Slave lock and four clean frames
        Enable = 1'b0; step(1'b0);
        Mode = 1'b1; Enable = 1'b1; step(1'b0);
        lr_c = 0;
        repeat (33) slave_tick();
        check("hunt_no_ld", int'(ld0), 0);
        slave_tick();
        check("lock_ld", int'(ld0), 1);
        repeat (256) begin
            slave_tick();
            step(1'b0);
        end
        check("slave_no_err0", int'(err0), 0);
        check("slave_no_err1", int'(err1), 0);

        // Falling edge five ticks early
        while (lr_c % 64 != 27) slave_tick();
        lr_c += 5;
        slave_tick();
        slave_tick();
        check("early_bc", int'(bc0), 0);
        check("early_slot", int'(sl0), 0);
        check("early_ld", int'(ld0), 1);
        check("early_err", int'(err0), 1);
        repeat (100) slave_tick();
        check("err_sticky", int'(err0), 1);
        Enable = 1'b0; step(1'b0);
        check("err_cleared", int'(err0), 0);

        // Randomized traffic against the model
        Enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            Enable = ($urandom_range(0, 299) != 0);
            Mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) lr_c += $urandom_range(1, 6);
            LRCLKIn = ((lr_c / 32) % 2 == 0);
            t = ($urandom_range(0, 2) == 0);
            step(t);
            if (t) lr_c++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
